// File: rtl/sram_controller.sv
// Word-access responder that splits each 32-bit request into two 16-bit async SRAM cycles.
// Optional one-entry last-read cache when SRAM_LAST_READ_CACHE_EN is defined.
module sram_controller #(
  parameter int ACCESS_CYCLES = 6,
  parameter int BASE_ADDR     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w_en,
  input  logic        mem_r_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] sram_dq,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n
);

  localparam int CW = $clog2(ACCESS_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [CW-1:0] r_cnt;
  logic        r_is_write;
  logic [16:0] r_word;
  logic [15:0] r_wdata_hi;
  logic [15:0] r_dq_out;
  logic        r_dq_oe;
  logic        r_we_n;
  logic [17:0] r_addr;
  logic [31:0] r_rdata;

  logic        w_req;
  logic        w_hit;
  logic        w_start;
  logic        w_lo;
  logic        w_hi;
  logic        w_last;
  logic [16:0] w_word;

  assign w_req   = mem_w_en | mem_r_en;
  assign w_word  = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign w_start = (r_state == IDLE) && w_req && !w_hit;
  assign w_lo    = (r_state == ACCESS) && (r_cnt == '0);
  assign w_hi    = (r_state == ACCESS) && (r_cnt == CW'(1));
  assign w_last  = (r_cnt == CW'(ACCESS_CYCLES - 2));

`ifdef SRAM_LAST_READ_CACHE_EN
  // rdata itself is the cached word; only the tag and valid bit are extra state
  logic        r_c_valid;
  logic [16:0] r_c_word;

  assign w_hit = mem_r_en && !mem_w_en && r_c_valid && (r_c_word == w_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_valid <= 1'b0;
      r_c_word  <= '0;
    end else if (w_start && mem_w_en) begin
      if (r_c_word == w_word) r_c_valid <= 1'b0;
    end else if (w_hi && !r_is_write) begin
      r_c_valid <= 1'b1;
      r_c_word  <= r_word;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    case (r_state)
      IDLE: begin
        ready = !w_start;
        if (w_start) w_next = ACCESS;
      end
      ACCESS: if (w_last) w_next = DONE;
      DONE: begin
        ready  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_cnt <= '0;
    else if (w_start)    r_cnt <= '0;
    else if (r_state == ACCESS) r_cnt <= r_cnt + CW'(1);
  end

  // SRAM pins are registered so they are already valid at the start of each half cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write <= 1'b0;
      r_word     <= '0;
      r_wdata_hi <= '0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_we_n     <= 1'b1;
      r_addr     <= '0;
      r_rdata    <= '0;
    end else if (w_start) begin
      r_is_write <= mem_w_en;
      r_word     <= w_word;
      r_wdata_hi <= wdata[31:16];
      r_dq_out   <= wdata[15:0];
      r_dq_oe    <= mem_w_en;
      r_we_n     <= !mem_w_en;
      r_addr     <= {w_word, 1'b0};
    end else if (w_lo) begin
      r_addr   <= {r_word, 1'b1};
      r_dq_out <= r_wdata_hi;
      if (!r_is_write) r_rdata[15:0] <= sram_dq;
    end else if (w_hi) begin
      r_we_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      if (!r_is_write) r_rdata[31:16] <= sram_dq;
    end
  end

  assign sram_dq   = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign sram_addr = r_addr;
  assign sram_we_n = r_we_n;
  assign rdata     = r_rdata;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM model plus a word-level reference memory and cache model.
module tb_sram_controller;

  localparam int AC = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_w_en, mem_r_en;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  logic [15:0] sram_mem [0:262143];
  logic [31:0] ref_mem [0:63];
  logic        model_oe;
  int          we_total = 0;

  int          n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] exp_rd;
  logic        cv;
  int          ct;

  sram_controller #(.ACCESS_CYCLES(AC), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (sram_dq[i]);
  end

  assign sram_dq = (model_oe && sram_we_n && !sram_oe_n && !sram_ce_n) ? sram_mem[sram_addr] : 16'hzzzz;

  // SRAM storage: preset from the reference words, then latch writes each cycle we_n is low
  initial begin
    #1;
    for (int w = 0; w < 64; w++) begin
      sram_mem[2*w]   = ref_mem[w][15:0];
      sram_mem[2*w+1] = ref_mem[w][31:16];
    end
    forever begin
      @(posedge clk);
      if (!sram_we_n && !sram_ce_n) begin
        sram_mem[sram_addr] = sram_dq;
        we_total++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input bit hold, output int lat);
    mem_w_en = w; mem_r_en = r; address = a; wdata = d;
    lat = 0;
    #1;
    while (ready !== 1'b1 && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    if (!hold) begin mem_w_en = 1'b0; mem_r_en = 1'b0; end
  endtask

  function automatic int exp_lat(input logic w, input logic r, input int wd);
    int el;
    el = AC;
`ifdef SRAM_LAST_READ_CACHE_EN
    if (!w && r && cv && ct == wd) el = 0;
`endif
    return el;
  endfunction

  function automatic void model_update(input logic w, input logic r, input int wd, input logic [31:0] d);
    if (w) begin
      ref_mem[wd] = d;
      if (cv && ct == wd) cv = 1'b0;
    end else if (r) begin
      exp_rd = ref_mem[wd];
      cv = 1'b1;
      ct = wd;
    end
  endfunction

  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    int lat, el, wc0, wd;
    wd  = int'((a - 32'd1024) >> 2);
    el  = exp_lat(w, r, wd);
    wc0 = we_total;
    xfer(w, r, a, d, 1'b0, lat);
    @(negedge clk);
    model_update(w, r, wd, d);
    chk("latency", 32'(lat), 32'(el));
    chk("we_cycles", 32'(we_total - wc0), w ? 32'd2 : 32'd0);
    chk("rdata", rdata, exp_rd);
    if (w) chk("sram_word", {sram_mem[2*wd+1], sram_mem[2*wd]}, ref_mem[wd]);
  endtask

  initial begin
    int lat, wc0;
    for (int w = 0; w < 64; w++) ref_mem[w] = $urandom;
    exp_rd = '0; cv = 1'b0; ct = 0;
    rst = 1'b1; model_oe = 1'b1;
    mem_w_en = 1'b0; mem_r_en = 1'b0; address = 32'd1024; wdata = '0;
    #3;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    chk("sram0", {16'd0, sram_mem[0]}, 32'h0000BEEF);
    chk("sram1", {16'd0, sram_mem[1]}, 32'h0000DEAD);
    op(1'b0, 1'b1, 32'd1024, 32'd0);
    chk("readback", rdata, 32'hDEADBEEF);

    op(1'b1, 1'b0, 32'd1032, 32'h12345678);
    chk("sram4", {16'd0, sram_mem[4]}, 32'h00005678);
    chk("sram5", {16'd0, sram_mem[5]}, 32'h00001234);
    op(1'b0, 1'b1, 32'd1028, 32'd0);

    // request held through DONE starts a second full access
    wc0 = we_total;
    xfer(1'b1, 1'b0, 32'd1036, 32'hA5A5C3C3, 1'b1, lat);
    chk("b2b_lat1", 32'(lat), 32'(AC));
    @(negedge clk);
    xfer(1'b1, 1'b0, 32'd1036, 32'hA5A5C3C3, 1'b0, lat);
    chk("b2b_lat2", 32'(lat), 32'(AC));
    @(negedge clk);
    model_update(1'b1, 1'b0, 3, 32'hA5A5C3C3);
    chk("b2b_we", 32'(we_total - wc0), 32'd4);

    op(1'b1, 1'b1, 32'd1040, 32'h0BADF00D);
    chk("both_rdata", rdata, 32'h12345678 ^ 32'h12345678 ^ exp_rd);

    // async reset while the controller drives the low half of a write
    mem_w_en = 1'b1; address = 32'd1024 + 32'd240; wdata = 32'hCAFE1234;
    @(negedge clk); #1;
    chk("wr_dq_lo", {16'd0, sram_dq}, 32'h00001234);
    model_oe = 1'b0; mem_w_en = 1'b0;
    rst = 1'b1; #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("arst_dq_z", {16'd0, sram_dq}, 32'h0000FFFF);
    chk("arst_rdata", rdata, 32'd0);
    @(negedge clk); rst = 1'b0; model_oe = 1'b1;
    exp_rd = '0; cv = 1'b0;
    @(negedge clk);

    // reset during the high-half cycle of a read
    op(1'b0, 1'b1, 32'd1024, 32'd0);
    mem_r_en = 1'b1; address = 32'd1028;
    @(negedge clk);
    @(negedge clk);
    mem_r_en = 1'b0; #1;
    rst = 1'b1; #1;
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    exp_rd = '0; cv = 1'b0;
    @(negedge clk);

    op(1'b0, 1'b1, 32'd1024, 32'd0);
    op(1'b0, 1'b1, 32'd1024, 32'd0);
    op(1'b1, 1'b0, 32'd1024, 32'h600DCAFE);
    op(1'b0, 1'b1, 32'd1024, 32'd0);
    op(1'b0, 1'b1, 32'd1024, 32'd0);

    for (int k = 0; k < 24; k++) begin
      int wd, kind;
      wd   = $urandom_range(0, 7);
      kind = $urandom_range(0, 3);
      op(kind >= 2, kind != 2, 32'd1024 + 32'(wd * 4), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
